dvp_rgb565_capture: RTL and testbench



---
 rtl/dvp_rgb565_capture_if.sv | 20 ++
 rtl/dvp_rgb565_capture.sv | 190 +++++++++++++++++++
 tb/tb_dvp_rgb565_capture.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_rgb565_capture_if.sv
// DVP camera inputs bundled with the pixel FIFO write port.
// The camera/FIFO side drives through master; the capture block uses slave.
interface dvp_rgb565_capture_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        fifo_full;
  logic [15:0] fifo_data_out;
  logic        fifo_write_en;

  modport master (
    output cam_vsync, cam_href, cam_data, fifo_full,
    input  fifo_data_out, fifo_write_en
  );

  modport slave (
    input  cam_vsync, cam_href, cam_data, fifo_full,
    output fifo_data_out, fifo_write_en
  );
endinterface

// File: rtl/dvp_rgb565_capture.sv
// OV5640 DVP capture stage on the camera pixel clock.
// Aligns to vsync, optionally skips settling frames, pairs bytes into RGB565
// pixels, clips to the display window and writes pixels into the FIFO,
// counting the pixels that are dropped while the FIFO is full.
module dvp_rgb565_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2,
  parameter bit VSYNC_POL   = 1'b1
) (
  input  logic                       clock,
  input  logic                       resetn,
  dvp_rgb565_capture_if.slave        bus,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       overflow,
  output logic [15:0]                drop_count,
  output logic                       sync_error
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);
  localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_VS,
    WAIT_END,
    SKIP,
    CAPTURE
  } state_t;

  state_t state_q, state_d;

  logic              vsync_d1, vsync_d2;
  logic              href_d1, href_d2;
  logic [7:0]        data_d1;
  logic              phase_q;
  logic [7:0]        high_q;
  logic [COL_W-1:0]  col_q;
  logic [LINE_W-1:0] line_q;
  logic [SKIP_W-1:0] skip_q;

  logic vs_act, vs_act_d2, vs_rise, vs_fall, href_fall;
  logic pixel_valid, in_window, write_slot;
  logic start_d, done_d, skip_inc;

  assign vs_act      = (vsync_d1 == VSYNC_POL);
  assign vs_act_d2   = (vsync_d2 == VSYNC_POL);
  assign vs_rise     = vs_act & ~vs_act_d2;
  assign vs_fall     = ~vs_act & vs_act_d2;
  assign href_fall   = href_d2 & ~href_d1;
  assign pixel_valid = href_d1 & phase_q;
  assign in_window   = (col_q < COL_MAX) && (line_q < LINE_MAX);
  // An active vsync overrides any simultaneous href, so no pixel slips out
  // while the frame is being closed.
  assign write_slot  = (state_q == CAPTURE) && pixel_valid && in_window && !vs_act;

  // Register the DVP pins once, plus a second copy for edge detection.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vsync_d1 <= 1'b0;
      vsync_d2 <= 1'b0;
      href_d1  <= 1'b0;
      href_d2  <= 1'b0;
      data_d1  <= 8'h00;
    end else begin
      vsync_d1 <= bus.cam_vsync;
      vsync_d2 <= vsync_d1;
      href_d1  <= bus.cam_href;
      href_d2  <= href_d1;
      data_d1  <= bus.cam_data;
    end
  end

  // Frame alignment: wait for a full vsync interval, then skip or capture.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    skip_inc = 1'b0;
    unique case (state_q)
      WAIT_VS: begin
        if (vs_act) state_d = WAIT_END;
      end
      WAIT_END: begin
        if (vs_fall) begin
          if (int'(skip_q) < SKIP_FRAMES) begin
            state_d = SKIP;
          end else begin
            state_d = CAPTURE;
            start_d = 1'b1;
          end
        end
      end
      SKIP: begin
        if (vs_rise) begin
          skip_inc = 1'b1;
          state_d  = WAIT_END;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          done_d  = 1'b1;
          state_d = WAIT_END;
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  // State register and the count of settling frames already discarded.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= WAIT_VS;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      if (skip_inc) skip_q <= skip_q + 1'b1;
    end
  end

  // Byte phase: even bytes are the high half, odd bytes complete a pixel.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      phase_q <= 1'b0;
      high_q  <= 8'h00;
    end else if (!href_d1) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      if (!phase_q) high_q <= data_d1;
    end
  end

  // Column and line position used to clip to the display window.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_q  <= '0;
      line_q <= '0;
    end else begin
      if (!href_d1) begin
        col_q <= '0;
      end else if (pixel_valid && (col_q < COL_MAX)) begin
        col_q <= col_q + 1'b1;
      end
      if (start_d) begin
        line_q <= '0;
      end else if (href_fall && (line_q < LINE_MAX)) begin
        line_q <= line_q + 1'b1;
      end
    end
  end

  // FIFO write port, drop accounting and odd-length line detection.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      bus.fifo_write_en <= 1'b0;
      bus.fifo_data_out <= 16'h0000;
      overflow          <= 1'b0;
      drop_count        <= 16'h0000;
      sync_error        <= 1'b0;
    end else begin
      bus.fifo_write_en <= 1'b0;
      if (write_slot) begin
        if (!bus.fifo_full) begin
          bus.fifo_write_en <= 1'b1;
          bus.fifo_data_out <= {high_q, data_d1};
        end else begin
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
      end
      if (!href_d1 && phase_q) sync_error <= 1'b1;
    end
  end

  // Registered one-cycle frame boundary pulses.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= start_d;
      frame_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Directed bench for dvp_rgb565_capture with a 4x2 window.
// dut0 captures every frame; dut2 discards two settling frames.
module tb_dvp_rgb565_capture;

  logic        clock = 1'b0;
  logic        resetn0, resetn2;
  logic        cam_vsync, cam_href, fifo_full;
  logic [7:0]  cam_data;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_start0 = 0, n_done0 = 0, n_start2 = 0, n_done2 = 0;
  int lat_edge = -1;
  int saved_starts;

  logic [15:0] wr0[$];
  logic [15:0] wr2[$];
  int          wcyc0[$];

  logic [15:0] exp_px [4] = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
  logic [15:0] exp_s3 [5] = '{16'h1122, 16'h1122, 16'h3344, 16'h5566, 16'h7788};
  logic [15:0] exp_s5 [7] = '{16'h1122, 16'h3344, 16'h5566,
                              16'h1122, 16'h3344, 16'h5566, 16'h7788};

  logic        frame_start0, frame_done0, overflow0, sync_error0;
  logic [15:0] drop_count0;
  logic        frame_start2, frame_done2, overflow2, sync_error2;
  logic [15:0] drop_count2;

  dvp_rgb565_capture_if bus0();
  dvp_rgb565_capture_if bus2();

  assign bus0.cam_vsync = cam_vsync;
  assign bus0.cam_href  = cam_href;
  assign bus0.cam_data  = cam_data;
  assign bus0.fifo_full = fifo_full;
  assign bus2.cam_vsync = cam_vsync;
  assign bus2.cam_href  = cam_href;
  assign bus2.cam_data  = cam_data;
  assign bus2.fifo_full = fifo_full;

  dvp_rgb565_capture #(
    .H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(0), .VSYNC_POL(1'b1)
  ) dut0 (
    .clock(clock), .resetn(resetn0), .bus(bus0),
    .frame_start(frame_start0), .frame_done(frame_done0),
    .overflow(overflow0), .drop_count(drop_count0), .sync_error(sync_error0)
  );

  dvp_rgb565_capture #(
    .H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(2), .VSYNC_POL(1'b1)
  ) dut2 (
    .clock(clock), .resetn(resetn2), .bus(bus2),
    .frame_start(frame_start2), .frame_done(frame_done2),
    .overflow(overflow2), .drop_count(drop_count2), .sync_error(sync_error2)
  );

  // Free-running pixel clock.
  always #5 clock = ~clock;

  // Rising edge counter used to measure write latency.
  always @(posedge clock) cyc <= cyc + 1;

  // Collect FIFO writes and frame pulses on the falling edge.
  always @(negedge clock) begin
    if (bus0.fifo_write_en) begin
      wr0.push_back(bus0.fifo_data_out);
      wcyc0.push_back(cyc);
    end
    if (bus2.fifo_write_en) wr2.push_back(bus2.fifo_data_out);
    if (frame_start0) n_start0++;
    if (frame_done0)  n_done0++;
    if (frame_start2) n_start2++;
    if (frame_done2)  n_done2++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic vs, input logic hr, input logic [7:0] d,
                       input logic full);
    cam_vsync = vs;
    cam_href  = hr;
    cam_data  = d;
    fifo_full = full;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    idle(4);
  endtask

  // One line of nbytes bytes 0x11,0x22,...; fifo_full is raised in the
  // cycle each pixel in [full_lo, full_hi] is decided.
  task automatic applyStimulus(input int nbytes, input int full_lo, input int full_hi);
    for (int j = 0; j <= nbytes; j++) begin
      logic full;
      full = (j >= 2) && ((j - 1) % 2 == 1) &&
             (((j - 1) / 2) >= full_lo) && (((j - 1) / 2) <= full_hi);
      if (j == 1 && lat_edge < 0) lat_edge = cyc + 1;
      if (j < nbytes) drive(1'b0, 1'b1, 8'((j + 1) * 17), full);
      else            drive(1'b0, 1'b0, 8'h00, full);
    end
    idle(2);
  endtask

  initial begin
    resetn0 = 1'b0; resetn2 = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00; fifo_full = 1'b0;
    @(negedge clock);
    idle(3);

    checkOutput("rst_wen0",    bus0.fifo_write_en, 0);
    checkOutput("rst_data0",   bus0.fifo_data_out, 0);
    checkOutput("rst_fs0",     frame_start0, 0);
    checkOutput("rst_fd0",     frame_done0, 0);
    checkOutput("rst_ovf0",    overflow0, 0);
    checkOutput("rst_drop0",   drop_count0, 0);
    checkOutput("rst_sync0",   sync_error0, 0);
    checkOutput("rst_wen2",    bus2.fifo_write_en, 0);
    checkOutput("rst_drop2",   drop_count2, 0);

    resetn0 = 1'b1;
    idle(2);

    // Basic frame: 2 lines of 8 bytes
    vsync_pulse();
    checkOutput("s1_frame_start", n_start0, 1);
    applyStimulus(8, -1, -1);
    applyStimulus(8, -1, -1);
    idle(2);
    checkOutput("s1_writes", wr0.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wr0.size()) checkOutput("s1_data", wr0[i], exp_px[i % 4]);
    checkOutput("s1_latency", (wcyc0.size() > 0) ? wcyc0[0] : -1, lat_edge + 1);
    checkOutput("s1_no_done_yet", n_done0, 0);
    vsync_pulse();
    checkOutput("s1_frame_done", n_done0, 1);
    checkOutput("s1_next_start", n_start0, 2);

    // Clipping: 3 lines of 6 pixels
    wr0.delete();
    applyStimulus(12, -1, -1);
    applyStimulus(12, -1, -1);
    applyStimulus(12, -1, -1);
    idle(2);
    checkOutput("s2_writes", wr0.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wr0.size()) checkOutput("s2_data", wr0[i], exp_px[i % 4]);
    checkOutput("s2_drop", drop_count0, 0);
    checkOutput("s2_ovf", overflow0, 0);
    vsync_pulse();

    // FIFO full for pixels 1..3 of the first line
    wr0.delete();
    applyStimulus(8, 1, 3);
    applyStimulus(8, -1, -1);
    idle(2);
    checkOutput("s3_writes", wr0.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wr0.size()) checkOutput("s3_data", wr0[i], exp_s3[i]);
    checkOutput("s3_ovf", overflow0, 1);
    checkOutput("s3_drop", drop_count0, 3);
    checkOutput("s3_sync_clean", sync_error0, 0);
    vsync_pulse();

    // Odd byte count line, then a clean line
    wr0.delete();
    applyStimulus(7, -1, -1);
    checkOutput("s5_sync_err", sync_error0, 1);
    applyStimulus(8, -1, -1);
    idle(2);
    checkOutput("s5_writes", wr0.size(), 7);
    for (int i = 0; i < 7; i++)
      if (i < wr0.size()) checkOutput("s5_data", wr0[i], exp_s5[i]);
    vsync_pulse();

    // Reset for one edge in the middle of a line
    wr0.delete();
    for (int j = 0; j < 6; j++) drive(1'b0, 1'b1, 8'((j + 1) * 17), 1'b0);
    resetn0 = 1'b0;
    drive(1'b0, 1'b1, 8'h77, 1'b0);
    checkOutput("s6_rst_wen",  bus0.fifo_write_en, 0);
    checkOutput("s6_rst_data", bus0.fifo_data_out, 0);
    checkOutput("s6_rst_ovf",  overflow0, 0);
    checkOutput("s6_rst_drop", drop_count0, 0);
    checkOutput("s6_rst_sync", sync_error0, 0);
    resetn0 = 1'b1;
    drive(1'b0, 1'b1, 8'h88, 1'b0);
    idle(3);
    checkOutput("s6_pre_writes", wr0.size(), 2);
    if (wr0.size() >= 2) begin
      checkOutput("s6_pre_d0", wr0[0], 16'h1122);
      checkOutput("s6_pre_d1", wr0[1], 16'h3344);
    end
    saved_starts = n_start0;
    applyStimulus(8, -1, -1);
    checkOutput("s6_no_vsync_writes", wr0.size(), 2);
    vsync_pulse();
    checkOutput("s6_restart", n_start0, saved_starts + 1);
    applyStimulus(8, -1, -1);
    checkOutput("s6_resume_writes", wr0.size(), 6);
    if (wr0.size() >= 6) begin
      checkOutput("s6_resume_first", wr0[2], 16'h1122);
      checkOutput("s6_resume_last",  wr0[5], 16'h7788);
    end

    // Settling frames on dut2
    resetn2 = 1'b1;
    idle(2);
    vsync_pulse();
    applyStimulus(8, -1, -1);
    vsync_pulse();
    applyStimulus(8, -1, -1);
    checkOutput("s4_skip_writes", wr2.size(), 0);
    checkOutput("s4_skip_starts", n_start2, 0);
    vsync_pulse();
    applyStimulus(8, -1, -1);
    checkOutput("s4_start", n_start2, 1);
    checkOutput("s4_writes", wr2.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wr2.size()) checkOutput("s4_data", wr2[i], exp_px[i]);
    checkOutput("s4_no_done_yet", n_done2, 0);
    vsync_pulse();
    checkOutput("s4_done", n_done2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
